// File: rtl/lpf_pkg.sv
// Shared constants and helpers for the low-pass filter output path.
package lpf_pkg;

  // Defaults shared with the transposed FIR (coefficient gain ~128).
  localparam int C_IWIDTH_DEF = 32;
  localparam int C_SHIFT_DEF  = 7;

  // Largest value representable in a signed field of width w.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed field of width w.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Half an LSB of the shifted result, added before the shift for round-half-up.
  function automatic longint round_const(input int shift);
    return longint'(1) <<< (shift - 1);
  endfunction

endpackage

// File: rtl/lpf_out_fmt_if.sv
// Valid/ready sample stream leaving the output formatter.
interface lpf_out_fmt_if #(
  parameter int C_OWIDTH = 16
);
  logic                       valid;
  logic signed [C_OWIDTH-1:0] data;
  logic                       rdy;

  modport master (output valid, output data, input  rdy);
  modport slave  (input  valid, input  data, output rdy);
endinterface

// File: rtl/lpf_sfifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted when a pop happens at the same edge.
module lpf_sfifo #(
  parameter int C_DWIDTH = 16,
  parameter int C_AWIDTH = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                push,
  input  logic [C_DWIDTH-1:0] din,
  input  logic                pop,
  output logic [C_DWIDTH-1:0] dout,
  output logic                full,
  output logic                empty,
  output logic [C_AWIDTH:0]   count
);

  localparam int DEPTH = 2 ** C_AWIDTH;

  logic [C_DWIDTH-1:0] mem [DEPTH];
  logic [C_AWIDTH-1:0] wptr, rptr;
  logic                do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (C_AWIDTH + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  // Storage write port.
  // NOTE: the data array has no reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally modulo the depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lpf_out_fmt.sv
// FIR output formatter: round-half-up rescale, saturate, decimate, and
// buffer kept samples behind a valid/ready stream with sticky status.
module lpf_out_fmt
  import lpf_pkg::*;
#(
  parameter int C_IWIDTH      = C_IWIDTH_DEF,
  parameter int C_OWIDTH      = 16,
  parameter int C_SHIFT       = C_SHIFT_DEF,
  parameter int C_DECIM       = 4,
  parameter int C_FIFO_AWIDTH = 3,
  parameter int C_DCNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       fir_en,
  input  logic signed [C_IWIDTH-1:0] fir_dout,
  input  logic                       clr_flags,
  lpf_out_fmt_if.master              m,
  output logic                       sat_flag,
  output logic                       ovf_flag,
  output logic [C_DCNT_WIDTH-1:0]    drop_cnt
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int SW = C_IWIDTH + 1;
  localparam int PW = (C_DECIM > 1) ? $clog2(C_DECIM) : 1;
  localparam logic signed [SW-1:0] RND  = SW'(round_const(C_SHIFT));
  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(C_OWIDTH));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(C_OWIDTH));

  logic                       en_d;
  logic                       s1_vld;
  logic signed [C_OWIDTH-1:0] s1_data;
  logic [PW-1:0]              phase;
  logic signed [SW-1:0]       sum, r;
  logic signed [C_OWIDTH-1:0] clip_val;
  logic                       clip_hit;
  logic                       keep, fifo_pop, fifo_full, fifo_empty, drop;
  logic [C_FIFO_AWIDTH:0]     fifo_count;
  logic [C_OWIDTH-1:0]        fifo_dout;

  assign sum = $signed({fir_dout[C_IWIDTH-1], fir_dout}) + RND;
  assign r   = sum >>> C_SHIFT;

  // Clip the rescaled value into the output range.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    clip_hit = 1'b0;
    clip_val = r[C_OWIDTH-1:0];
    if (r > MAXV) begin
      clip_hit = 1'b1;
      clip_val = MAXV[C_OWIDTH-1:0];
    end else if (r < MINV) begin
      clip_hit = 1'b1;
      clip_val = MINV[C_OWIDTH-1:0];
    end
  end

  // Stage 0/1 pipeline: delay the strobe, then capture the formatted sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_d    <= 1'b0;
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      en_d   <= fir_en;
      s1_vld <= en_d;
      if (en_d) s1_data <= clip_val;
    end
  end

  // Decimation phase: only phase-0 samples reach the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= '0;
    end else if (s1_vld) begin
      phase <= (phase == PW'(C_DECIM - 1)) ? '0 : phase + 1'b1;
    end
  end

  assign keep     = s1_vld && (phase == '0);
  assign fifo_pop = m.rdy && !fifo_empty;
  assign drop     = keep && fifo_full && !fifo_pop;

  lpf_sfifo #(
    .C_DWIDTH(C_OWIDTH),
    .C_AWIDTH(C_FIFO_AWIDTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (keep),
    .din  (s1_data),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign m.valid = (fifo_count != '0);
  assign m.data  = fifo_dout;

  // Sticky status; a set event at the same edge as clr_flags wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (en_d && clip_hit) sat_flag <= 1'b1;
      else if (clr_flags)   sat_flag <= 1'b0;
      if (drop)           ovf_flag <= 1'b1;
      else if (clr_flags) ovf_flag <= 1'b0;
      if (drop)           drop_cnt <= (drop_cnt == '1) ? drop_cnt : drop_cnt + 1'b1;
      else if (clr_flags) drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_lpf_out_fmt.sv
// Directed bench: one instance keeps every sample, one decimates by 4.
module tb_lpf_out_fmt;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en1 = 1'b0, clr1 = 1'b0;
  logic en4 = 1'b0, clr4 = 1'b0;
  logic signed [31:0] dout1 = '0, dout4 = '0;
  logic sat1, ovf1, sat4, ovf4;
  logic [7:0] drop1, drop4;

  int n_checks = 0;
  int n_pass   = 0;
  int got1[$];
  int got4[$];
  int exp_q[$];

  lpf_out_fmt_if #(.C_OWIDTH(16)) m1 ();
  lpf_out_fmt_if #(.C_OWIDTH(16)) m4 ();

  lpf_out_fmt #(.C_DECIM(1)) dut1 (
    .clk(clk), .rstn(rstn), .fir_en(en1), .fir_dout(dout1), .clr_flags(clr1),
    .m(m1), .sat_flag(sat1), .ovf_flag(ovf1), .drop_cnt(drop1)
  );

  lpf_out_fmt #(.C_DECIM(4)) dut4 (
    .clk(clk), .rstn(rstn), .fir_en(en4), .fir_dout(dout4), .clr_flags(clr4),
    .m(m4), .sat_flag(sat4), .ovf_flag(ovf4), .drop_cnt(drop4)
  );

  always #5 clk = ~clk;

  // Record every accepted beat, sampled mid-cycle.
  always @(negedge clk) begin
    if (m1.valid && m1.rdy) got1.push_back(int'(m1.data));
    if (m4.valid && m4.rdy) got4.push_back(int'(m4.data));
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1(input logic signed [31:0] v);
    en1 = 1'b1;
    tick();
    en1   = 1'b0;
    dout1 = v;
  endtask

  task automatic pulse4(input logic signed [31:0] v);
    en4 = 1'b1;
    tick();
    en4   = 1'b0;
    dout4 = v;
  endtask

  initial begin
    m1.rdy = 1'b0;
    m4.rdy = 1'b0;
    #12;
    check("rst_valid", m1.valid, 0);
    check("rst_data", m1.data, 0);
    check("rst_sat", sat1, 0);
    check("rst_ovf", ovf4, 0);
    check("rst_drop", drop4, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // Rounding and latency, keep-every-sample instance.
    pulse1(192);
    check("lat_e0", m1.valid, 0);
    tick();
    check("lat_e1", m1.valid, 0);
    tick();
    check("lat_e2", m1.valid, 1);
    pulse1(-192);
    repeat (2) tick();
    pulse1(63);
    repeat (4) tick();
    check("rnd_sat", sat1, 0);
    m1.rdy = 1'b1;
    repeat (5) tick();
    m1.rdy = 1'b0;
    exp_q = '{2, -1, 0};
    cmp_q("rnd", got1, exp_q);
    check("rnd_drop", drop1, 0);
    check("rnd_ovf", ovf1, 0);

    // Saturation at both rails, then clear.
    got1.delete();
    pulse1(32'h7FFF_FFFF);
    repeat (2) tick();
    pulse1(32'h8000_0000);
    repeat (3) tick();
    m1.rdy = 1'b1;
    repeat (4) tick();
    m1.rdy = 1'b0;
    exp_q = '{32767, -32768};
    cmp_q("sat", got1, exp_q);
    check("sat_flag_set", sat1, 1);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    check("sat_flag_clr", sat1, 0);

    // Decimation by 4 with the consumer always ready.
    m4.rdy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      pulse4(128 * k);
      repeat (2) tick();
    end
    repeat (4) tick();
    exp_q = '{1, 5};
    cmp_q("decim", got4, exp_q);
    check("decim_ovf", ovf4, 0);

    // Overflow: 40 back-to-back samples, 10 kept, consumer stalled.
    got4.delete();
    m4.rdy = 1'b0;
    for (int j = 0; j < 40; j++) begin
      en4 = 1'b1;
      tick();
      dout4 = 128 * (j / 4 + 1);
    end
    en4 = 1'b0;
    repeat (4) tick();
    check("ovf_flag", ovf4, 1);
    check("ovf_drop", drop4, 2);
    check("ovf_valid", m4.valid, 1);
    check("ovf_head", m4.data, 1);
    m4.rdy = 1'b1;
    repeat (10) tick();
    m4.rdy = 1'b0;
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 8};
    cmp_q("drain", got4, exp_q);
    check("drain_valid", m4.valid, 0);

    // Full FIFO with a pop at the same edge a kept sample arrives.
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    check("clr_ovf", ovf4, 0);
    check("clr_drop", drop4, 0);
    got4.delete();
    for (int j = 0; j < 32; j++) begin
      en4 = 1'b1;
      tick();
      dout4 = 128 * (10 + j / 4);
    end
    en4 = 1'b0;
    repeat (4) tick();
    check("refill_valid", m4.valid, 1);
    pulse4(128 * 100);
    tick();
    m4.rdy = 1'b1;
    tick();
    m4.rdy = 1'b0;
    for (int j = 0; j < 3; j++) pulse4(128 * 200);
    repeat (4) tick();
    check("fp_ovf", ovf4, 0);
    check("fp_drop", drop4, 0);
    m4.rdy = 1'b1;
    repeat (12) tick();
    m4.rdy = 1'b0;
    exp_q = '{10, 11, 12, 13, 14, 15, 16, 17, 100};
    cmp_q("fullpop", got4, exp_q);

    // Reset mid-stream: 5 queued, phase at 2, sat set.
    got4.delete();
    for (int j = 0; j < 18; j++) begin
      en4 = 1'b1;
      tick();
      dout4 = (j == 0) ? 32'sh7FFF_FFFF : 128 * (50 + j);
    end
    en4 = 1'b0;
    repeat (4) tick();
    check("pre_rst_sat", sat4, 1);
    check("pre_rst_valid", m4.valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid", m4.valid, 0);
    check("mid_rst_data", m4.data, 0);
    check("mid_rst_sat", sat4, 0);
    check("mid_rst_ovf", ovf4, 0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_valid", m4.valid, 0);
    m4.rdy = 1'b1;
    pulse4(128 * 42);
    repeat (6) tick();
    m4.rdy = 1'b0;
    exp_q = '{42};
    cmp_q("post_rst", got4, exp_q);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lpf_out_fmt.md
Name: lpf_out_fmt

Overview:
- Output stage directly downstream of the low-pass transposed FIR.
- Takes the filter's wide signed accumulator output plus the filter's `en` strobe, and rescales it by the coefficient gain with round-half-up.
- Saturates the result to the output width and decimates by a fixed ratio.
- Buffers kept samples in a small FIFO behind a valid/ready master interface. Also reports sticky saturation and overflow status.

Parameters:
- C_IWIDTH, 32, width of the filter accumulator input (signed).
- C_OWIDTH, 16, width of the output sample (signed); C_OWIDTH < C_IWIDTH - C_SHIFT + 1.
- C_SHIFT, 7, arithmetic right shift for gain compensation; must be >= 1.
- C_DECIM, 4, decimation ratio; >= 1; 1 = keep every sample.
- C_FIFO_AWIDTH, 3, FIFO address width; depth = 2**C_FIFO_AWIDTH (8).
- C_DCNT_WIDTH, 8, width of the dropped-sample counter.

Ports:
- clk, in, 1, single clock; all logic on its rising edge.
- rstn, in, 1, asynchronous active-low reset.
- fir_en, in, 1, the same enable strobe that drives the filter.
- fir_dout, in, C_IWIDTH, filter output; holds a new value after each fir_en edge.
- m_valid, out, 1, output sample available.
- m_data, out, C_OWIDTH, output sample (signed).
- m_rdy, in, 1, consumer accepts m_data when m_valid && m_rdy at a clock edge.
- clr_flags, in, 1, synchronous pulse that clears sat_flag, ovf_flag and drop_cnt.
- sat_flag, out, 1, sticky: a rescaled sample was clipped.
- ovf_flag, out, 1, sticky: a kept sample was dropped because the FIFO was full.
- drop_cnt, out, C_DCNT_WIDTH, number of dropped samples; saturates at all-ones (no wrap).

Behaviour:
- Reset (rstn=0, asynchronous): the following clear immediately.
  - en_d, stage registers, decimation phase (0) and FIFO pointers/count.
  - m_valid=0, m_data=0, sat_flag=0, ovf_flag=0, drop_cnt=0.
  - In-flight samples are discarded.
  - Release is synchronous to clk; the first fir_en edge after release is sample 0 (phase 0).
- Edge numbering: E0 is the edge at which fir_en=1, where the filter updates fir_dout.
- Stage 0, at E0: en_d <= fir_en.
- Stage 1, at E1 if en_d=1: r = (fir_dout + 2**(C_SHIFT-1)) >>> C_SHIFT.
  - r is computed at C_IWIDTH+1 bits so the addition never wraps.
  - If r > 2**(C_OWIDTH-1)-1, clip to max; if r < -2**(C_OWIDTH-1), clip to min. Either clip sets sat_flag at E1.
  - Result goes to s1_data, with s1_vld=1 for one cycle.
- Stage 2, at E2 if s1_vld=1 (decimation):
  - If phase==0, the sample is kept and pushed to the FIFO.
  - Phase then increments, wrapping C_DECIM-1 -> 0.
  - Non-kept samples are discarded silently (not counted as drops).
- FIFO (first-word-fall-through):
  - m_valid = (count != 0); m_data = mem[rptr] (0 when empty).
  - Pop on m_valid && m_rdy.
  - Push is accepted if count < depth, or if a pop occurs in the same cycle (full + simultaneous pop → both succeed, count unchanged).
  - Push rejected: ovf_flag <= 1 and drop_cnt increments (saturating). The FIFO contents are unchanged.
  - Pointers wrap modulo depth; count spans 0..depth.
- Latency: an empty FIFO and a kept sample give m_valid=1 in the cycle after E2, i.e. 3 edges after fir_en.
- Back-to-back fir_en every cycle is supported at full rate; no stalls are propagated upstream.
- clr_flags=1 at an edge clears the status flags. If a set event occurs at the same edge, the set wins.
- m_rdy is ignored while m_valid=0.

Decomposition:
- Package lpf_pkg holds:
  - Saturation-bound functions (max/min for a given width).
  - The round-constant function.
  - Default parameter constants shared with the filter (C_IWIDTH=32, C_SHIFT=7, matching coefficient gain ≈128).
- One sub-module: lpf_sfifo. It is a synchronous FWFT FIFO, parameterised by data width and address width, with push/pop/full/empty/count and accept-on-full-with-pop.

Test Plan:
- Rounding: C_DECIM=1; single fir_en with fir_dout=192, then -192, then 63 → m_data 2, -1, 0 in order. First m_valid appears 3 edges after the first fir_en; sat_flag=0.
- Saturation: fir_dout=32'h7FFFFFFF, then 32'h80000000 → m_data 32767, then -32768; sat_flag=1. Then a clr_flags pulse → sat_flag=0.
- Decimation: C_DECIM=4, m_rdy=1; 8 fir_en pulses (one every 3 cycles) with fir_dout=128*k, k=1..8 → exactly two outputs, 1 then 5.
- Overflow: C_DECIM=4, m_rdy=0; 40 consecutive fir_en → 10 kept. Expected: count=8, ovf_flag=1, drop_cnt=2. Then m_rdy=1 drains 8 samples in order (phase-0 samples 1..8), and m_valid drops.
- Full + simultaneous pop: FIFO full, m_rdy=1 in the same cycle a kept sample arrives → push accepted, count stays 8, no drop counted.
- Reset mid-stream: assert rstn=0 for 1 cycle with 5 samples queued and the phase at 2 → m_valid=0 immediately, flags 0. The next kept sample is the first one after release.
